// File: rtl/psm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : psm_pkg
// Description : Shared definitions for the PSM (pulse-skipping modulation)
//               generator/decoder pair: decoder state type, default
//               resolution and skip limit, and the period helper.
// Revision    : 1.0 - initial release
// ============================================================================
package psm_pkg;

    // Defaults shared with the open-loop PSM generator
    localparam int unsigned c_DEF_RESOLUTION = 8;
    localparam int unsigned c_DEF_SKIP_MAX   = 15;

    // Decoder state
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } psm_state_t;

    // PWM period in clk cycles for a given resolution
    function automatic int unsigned period(input int unsigned resolution);
        return 32'd1 << resolution;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_edge_detect.sv
`default_nettype none
// ============================================================================
// Module      : sync_edge_detect
// Description : Two-flop synchronizer for an asynchronous input followed by a
//               delay flop, producing single-cycle rise and fall strobes.
// Ports       : clk    - system clock
//               rst    - asynchronous active-high reset
//               i_din  - asynchronous input
//               o_rise - synchronized level went 0 -> 1 this cycle
//               o_fall - synchronized level went 1 -> 0 this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module sync_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic i_din,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;   // first synchronizer stage, may go metastable
    logic r_s_q;    // synchronized level
    logic r_s_d;    // synchronized level delayed by one cycle

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_s_q  <= 1'b0;
            r_s_d  <= 1'b0;
        end else begin
            r_meta <= i_din;
            r_s_q  <= r_meta;
            r_s_d  <= r_s_q;
        end
    end

    assign o_rise =  r_s_q & ~r_s_d;
    assign o_fall = ~r_s_q &  r_s_d;

endmodule
`default_nettype wire

// File: rtl/psm_decoder.sv
`default_nettype none
// ============================================================================
// Module      : psm_decoder
// Description : Receive-side PSM decoder. For every received pulse reports
//               the previous pulse width, the number of empty PWM period
//               boundaries before the current rising edge, and whether that
//               edge landed on a period boundary. Flags loss of signal and
//               stuck-high input.
// Ports       : clk       - system clock
//               rst       - asynchronous active-high reset
//               psm_in    - PSM waveform (may be asynchronous to clk)
//               valid_o   - one-cycle strobe qualifying duty/skip/aligned
//               duty_o    - high time of previous pulse (clk cycles)
//               skip_o    - empty boundaries between previous pulse and edge
//               aligned_o - current rising edge fell on a period boundary
//               lost_o    - level: loss of signal or stuck-high detected
// Revision    : 1.0 - initial release
// ============================================================================
module psm_decoder
    import psm_pkg::*;
#(
    parameter int unsigned RESOLUTION = c_DEF_RESOLUTION,
    parameter int unsigned SKIP_MAX   = c_DEF_SKIP_MAX,
    localparam int unsigned SKIP_W    = $clog2(SKIP_MAX + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  psm_in,
    output logic                  valid_o,
    output logic [RESOLUTION-1:0] duty_o,
    output logic [SKIP_W-1:0]     skip_o,
    output logic                  aligned_o,
    output logic                  lost_o
);

    localparam logic [RESOLUTION-1:0] c_CNT_ONE  = RESOLUTION'(1);
    localparam logic [SKIP_W-1:0]     c_SKIP_MAX = SKIP_W'(SKIP_MAX);

    logic w_rise;
    logic w_fall;
    logic w_boundary;

    psm_state_t            r_state;
    logic [RESOLUTION-1:0] r_slot_cnt;   // position within the current period
    logic [RESOLUTION-1:0] r_width_cnt;  // high time of the pulse in progress
    logic [RESOLUTION-1:0] r_duty;       // width of the last completed pulse
    logic [SKIP_W-1:0]     r_skip_acc;   // empty boundaries since last pulse

    sync_edge_detect u_sync (
        .clk    (clk),
        .rst    (rst),
        .i_din  (psm_in),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    // The period grid is anchored to the last rising edge; slot 0 marks
    // a boundary. Meaningless while idle, so it is masked there.
    assign w_boundary = (r_slot_cnt == '0) && (r_state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_slot_cnt  <= '0;
            r_width_cnt <= '0;
            r_duty      <= '0;
            r_skip_acc  <= '0;
            valid_o     <= 1'b0;
            duty_o      <= '0;
            skip_o      <= '0;
            aligned_o   <= 1'b0;
            lost_o      <= 1'b0;
        end else begin
            valid_o <= 1'b0;

            // Rising edge is slot 0, so the following cycle is slot 1
            if (w_rise) begin
                r_slot_cnt <= c_CNT_ONE;
            end else begin
                r_slot_cnt <= r_slot_cnt + c_CNT_ONE;
            end

            case (r_state)
                IDLE: begin
                    // First pulse after idle has no predecessor to report
                    if (w_rise) begin
                        lost_o      <= 1'b0;
                        r_skip_acc  <= '0;
                        r_width_cnt <= c_CNT_ONE;
                        r_state     <= HIGH;
                    end
                end

                HIGH: begin
                    // Reaching a boundary while high means the pulse spans
                    // a full period; this also keeps width_cnt from wrapping.
                    if (w_boundary) begin
                        lost_o  <= 1'b1;
                        r_state <= IDLE;
                    end else if (w_fall) begin
                        r_duty  <= r_width_cnt;
                        r_state <= LOW;
                    end else begin
                        r_width_cnt <= r_width_cnt + c_CNT_ONE;
                    end
                end

                LOW: begin
                    // A rise landing on a boundary is a new pulse, not a skip
                    if (w_rise) begin
                        valid_o     <= 1'b1;
                        duty_o      <= r_duty;
                        skip_o      <= r_skip_acc;
                        aligned_o   <= (r_slot_cnt == '0);
                        r_width_cnt <= c_CNT_ONE;
                        r_skip_acc  <= '0;
                        r_state     <= HIGH;
                    end else if (w_boundary) begin
                        if (r_skip_acc == c_SKIP_MAX) begin
                            lost_o  <= 1'b1;
                            r_state <= IDLE;
                        end else begin
                            r_skip_acc <= r_skip_acc + SKIP_W'(1);
                        end
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_psm_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_psm_decoder
// Description : Self-checking bench for psm_decoder. Drives directed and
//               randomized PSM streams and compares every output each cycle
//               against a reference model built from pulse rise/fall times.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_psm_decoder;
    import psm_pkg::*;

    localparam int c_RES  = 8;
    localparam int c_SMAX = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic       psm_in;
    logic       valid_o;
    logic [7:0] duty_o;
    logic [3:0] skip_o;
    logic       aligned_o;
    logic       lost_o;

    psm_decoder #(
        .RESOLUTION (c_RES),
        .SKIP_MAX   (c_SMAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .psm_in    (psm_in),
        .valid_o   (valid_o),
        .duty_o    (duty_o),
        .skip_o    (skip_o),
        .aligned_o (aligned_o),
        .lost_o    (lost_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Works on input-cycle timestamps: a pulse rising at p has boundaries at
    // p + k*P. Overrun if still high at p+P, timeout at p+16P unless a rise
    // arrives at or before it.
    typedef struct {
        logic       v;
        logic [7:0] d;
        logic [3:0] s;
        logic       a;
        logic       l;
    } exp_t;

    exp_t       q[$];
    int         per_len;
    int         cyc;
    logic       vprev;
    bit         trk;     // a pulse has been seen and is being timed
    bit         inp;     // currently inside that pulse
    int         p_rise;
    int         f_fall;
    logic [7:0] m_duty;
    logic [3:0] m_skip;
    logic       m_al;
    logic       m_lost;

    task automatic model_clear();
        exp_t z;
        z = '{v: 1'b0, d: 8'd0, s: 4'd0, a: 1'b0, l: 1'b0};
        trk = 0; inp = 0; vprev = 1'b0;
        m_duty = '0; m_skip = '0; m_al = 1'b0; m_lost = 1'b0;
        q.delete();
        // the two synchronizer cycles still show the cleared outputs
        q.push_back(z);
        q.push_back(z);
    endtask

    task automatic tick(input logic v);
        exp_t e;
        logic ev;
        ev = 1'b0;
        psm_in = v;
        if (trk && inp && cyc == p_rise + per_len) begin
            m_lost = 1'b1; trk = 0;
        end
        if (v && !vprev) begin
            if (trk) begin
                ev     = 1'b1;
                m_duty = 8'(f_fall - p_rise);
                m_skip = 4'((cyc - p_rise - 1) / per_len);
                m_al   = ((cyc - p_rise) % per_len) == 0;
            end else begin
                m_lost = 1'b0;
            end
            trk = 1; inp = 1; p_rise = cyc;
        end else if (!v && vprev) begin
            if (trk && inp) begin
                inp = 0; f_fall = cyc;
            end
        end else if (trk && !inp && cyc == p_rise + (c_SMAX + 1) * per_len) begin
            m_lost = 1'b1; trk = 0;
        end
        vprev = v;
        q.push_back('{v: ev, d: m_duty, s: m_skip, a: m_al, l: m_lost});
        @(posedge clk);
        #1;
        cyc++;
        e = q.pop_front();
        chk("valid",   32'(valid_o),   32'(e.v));
        chk("lost",    32'(lost_o),    32'(e.l));
        chk("duty",    32'(duty_o),    32'(e.d));
        chk("skip",    32'(skip_o),    32'(e.s));
        chk("aligned", 32'(aligned_o), 32'(e.a));
    endtask

    task automatic pulse(input int h, input int per);
        for (int i = 0; i < h; i++) tick(1'b1);
        for (int i = 0; i < per - h; i++) tick(1'b0);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        #1;
        chk("rst_valid",   32'(valid_o),   32'd0);
        chk("rst_duty",    32'(duty_o),    32'd0);
        chk("rst_skip",    32'(skip_o),    32'd0);
        chk("rst_aligned", 32'(aligned_o), 32'd0);
        chk("rst_lost",    32'(lost_o),    32'd0);
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    int h;
    int per;
    int sel;

    initial begin
        per_len = int'(period(c_RES));
        cyc     = 0;
        rst     = 1'b1;
        psm_in  = 1'b0;
        repeat (3) @(posedge clk);
        do_reset(1);

        // generator-style stream: 128 high every 6 periods
        for (int i = 0; i < 4; i++) pulse(128, 1536);
        // continuous PWM
        for (int i = 0; i < 6; i++) pulse(64, 256);
        // unaligned arrival with one skipped boundary
        for (int i = 0; i < 3; i++) pulse(40, 300);
        // loss of signal, then recovery
        pulse(50, 4200);
        for (int i = 0; i < 3; i++) pulse(30, 256);
        // stuck high, then recovery
        pulse(300, 400);
        for (int i = 0; i < 3; i++) pulse(25, 512);
        // reset while low with three boundaries counted
        pulse(20, 256);
        pulse(20, 256);
        for (int i = 0; i < 20; i++) tick(1'b1);
        for (int i = 0; i < 780; i++) tick(1'b0);
        do_reset(3);
        for (int i = 0; i < 100; i++) tick(1'b0);
        pulse(15, 600);
        pulse(15, 300);
        pulse(15, 256);

        // randomized stream
        for (int i = 0; i < 40; i++) begin
            if (i == 20) begin
                // reset while psm_in is high: treated as a fresh rise
                for (int k = 0; k < 10; k++) tick(1'b1);
                do_reset(2);
                for (int k = 0; k < 20; k++) tick(1'b1);
                for (int k = 0; k < 200; k++) tick(1'b0);
            end
            h   = int'($urandom_range(1, 290));
            sel = int'($urandom_range(0, 7));
            if (sel == 0) begin
                per = h + int'($urandom_range(3800, 4400));
            end else if (sel < 3) begin
                per = 256 * int'($urandom_range(1, 6));
                if (per <= h) per += 256;
            end else begin
                per = h + int'($urandom_range(1, 700));
            end
            pulse(h, per);
        end
        pulse(10, 256);
        pulse(10, 256);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
